controlador_interrupciones: RTL

CONTROLADOR_INTERRUPCIONES -- requirements
Module: controlador_interrupciones

---
 rtl/controlador_interrupciones_pkg.sv | 29 ++
 rtl/controlador_interrupciones_sincronizador.sv | 35 +++
 rtl/controlador_interrupciones.sv | 107 ++++++++++
 3 files changed

// File: rtl/controlador_interrupciones_pkg.sv
`default_nettype none
// ============================================================================
// Module      : controlador_interrupciones_pkg
// Description : Shared declarations for the interrupt controller: FSM state
//               encoding, default base vector and priority helper.
// Revision    : 1.0 - initial release
// ============================================================================
package controlador_interrupciones_pkg;

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        PETICION = 2'd1,
        SERVICIO = 2'd2
    } estado_t;

    localparam logic [7:0] BASE_VECTOR_DEF = 8'h10;

    // Index of the lowest set bit (channel 0 has the highest priority).
    function automatic logic [2:0] indice_menor(input logic [7:0] bits);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (bits[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/controlador_interrupciones_sincronizador.sv
`default_nettype none
// ============================================================================
// Module      : sincronizador_flanco
// Description : Two-flop synchroniser for one asynchronous request line
//               followed by a rising-edge detector (one pulse per rise).
// Revision    : 1.0 - initial release
// ============================================================================
module sincronizador_flanco (
    input  logic clk,
    input  logic reset,
    input  logic linea_i,
    output logic pulso_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // Synchroniser chain plus one cycle of history for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= linea_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign pulso_o = sync2_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/controlador_interrupciones.sv
`default_nettype none
// ============================================================================
// Module      : controlador_interrupciones
// Description : Vectored, maskable interrupt controller with fixed priority
//               (lowest channel first) and a REPOSO/PETICION/SERVICIO
//               handshake towards the control unit.
// Revision    : 1.0 - initial release
// ============================================================================
module controlador_interrupciones
    import controlador_interrupciones_pkg::*;
#(
    parameter int                      N_INT        = 3,
    parameter int                      ANCHO_VECTOR = 8,
    parameter logic [ANCHO_VECTOR-1:0] BASE_VECTOR  = ANCHO_VECTOR'(BASE_VECTOR_DEF)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_INT-1:0]        interrupciones,
    input  logic                    we_mascara,
    input  logic [N_INT-1:0]        mascara_in,
    output logic [N_INT-1:0]        mascara,
    output logic [N_INT-1:0]        pendientes,
    output logic                    peticion,
    input  logic                    reconocimiento,
    input  logic                    fin_servicio,
    output logic [ANCHO_VECTOR-1:0] vector,
    output logic                    en_servicio
);

    estado_t                 estado_q, estado_d;
    logic [N_INT-1:0]        pend_q, pend_d;
    logic [N_INT-1:0]        mask_q, mask_d;
    logic [ANCHO_VECTOR-1:0] vector_q, vector_d;
    logic [N_INT-1:0]        flancos;
    logic [N_INT-1:0]        activas;
    logic [N_INT-1:0]        limpiar;
    logic [2:0]              idx;

    generate
        for (genvar g = 0; g < N_INT; g++) begin : g_sync
            sincronizador_flanco u_sync (
                .clk     (clk),
                .reset   (reset),
                .linea_i (interrupciones[g]),
                .pulso_o (flancos[g])
            );
        end
    endgenerate

    assign activas = pend_q & mask_q;
    assign idx     = indice_menor(8'(activas));

    // Next-state logic: request while enabled work is pending, grant the
    // lowest enabled channel on acknowledge, wait for end of routine.
    always_comb begin
        estado_d = estado_q;
        vector_d = vector_q;
        limpiar  = '0;
        case (estado_q)
            REPOSO: begin
                if (|activas) estado_d = PETICION;
            end
            PETICION: begin
                if (reconocimiento && (|activas)) begin
                    estado_d = SERVICIO;
                    limpiar  = N_INT'(8'd1 << idx);
                    vector_d = BASE_VECTOR + ANCHO_VECTOR'(idx);
                end else if (!(|activas)) begin
                    estado_d = REPOSO;
                end
            end
            SERVICIO: begin
                if (fin_servicio) estado_d = REPOSO;
            end
            default: estado_d = REPOSO;
        endcase
    end

    // New edges win over the grant clear of the same cycle.
    always_comb begin
        pend_d = (pend_q & ~limpiar) | flancos;
        mask_d = we_mascara ? mascara_in : mask_q;
    end

    // State, pending, mask and vector registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q <= REPOSO;
            pend_q   <= '0;
            mask_q   <= '1;
            vector_q <= '0;
        end else begin
            estado_q <= estado_d;
            pend_q   <= pend_d;
            mask_q   <= mask_d;
            vector_q <= vector_d;
        end
    end

    assign mascara     = mask_q;
    assign pendientes  = pend_q;
    assign vector      = vector_q;
    assign peticion    = (estado_q == PETICION);
    assign en_servicio = (estado_q == SERVICIO);

endmodule
`default_nettype wire
